unidade_controle_multiciclo: RTL and testbench

Multi-cycle control FSM that issues operations to the processor's 5-bit-aluOp ALU. It decodes opcode/funct and sequences fetch, decode, execute, memory and writeback. It produces aluOp, B-operand select, register/memory/PC write enables, and the IN/OUT handshakes. It consumes the ALU's flagBranch output to resolve jump-if-false.

---
 rtl/unidade_controle_multiciclo.sv | 260 ++++++++++++++++++++++++++
 tb/tb_unidade_controle_multiciclo.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_multiciclo.sv
// Multi-cycle control unit sequencing fetch/decode/execute/memory/writeback for the 5-bit-aluOp datapath.
// Optional instruction completion counter (instr_contador) enabled by defining INSTR_COUNTER_EN.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// BUSCA      | fetch: load IR, PC <= PC+1
// DECODIFICA | register read, opcode/funct captured, J/HLT/IN/illegal resolved
// EXECUTA    | ALU operation; JF resolved from flagBranch
// MEMORIA    | data memory read (LW) or write (SW)
// ESCRITA    | register file writeback (ALU or memory data)
// ESPERA_IN  | wait for input device data, write it to the register file
// ESPERA_OUT | present output data until the device accepts it
// PARADO     | halted (HLT or illegal instruction) until reset
module unidade_controle_multiciclo #(
    parameter int MEM_HANDSHAKE = 1,
    parameter int ALUOP_W       = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic [4:0]         funct,
    input  logic               flagBranch,
    input  logic               mem_pronto,
    input  logic               entrada_valida,
    input  logic               saida_aceita,
    output logic [ALUOP_W-1:0] aluOp,
    output logic               selB,
    output logic               escreveIR,
    output logic               escrevePC,
    output logic [1:0]         selPC,
    output logic               escreveReg,
    output logic [1:0]         selDadoReg,
    output logic               leMem,
    output logic               escreveMem,
    output logic               entrada_pronta,
    output logic               saida_valida,
    output logic               parado,
    output logic               ilegal
`ifdef INSTR_COUNTER_EN
    ,
    output logic [31:0]        instr_contador
`endif
);

    typedef enum logic [2:0] {
        BUSCA      = 3'd0,
        DECODIFICA = 3'd1,
        EXECUTA    = 3'd2,
        MEMORIA    = 3'd3,
        ESCRITA    = 3'd4,
        ESPERA_IN  = 3'd5,
        ESPERA_OUT = 3'd6,
        PARADO     = 3'd7
    } estado_t;

    localparam logic [5:0] OP_R    = 6'd0;
    localparam logic [5:0] OP_ADDI = 6'd1;
    localparam logic [5:0] OP_LW   = 6'd2;
    localparam logic [5:0] OP_SW   = 6'd3;
    localparam logic [5:0] OP_LI   = 6'd4;
    localparam logic [5:0] OP_JF   = 6'd5;
    localparam logic [5:0] OP_J    = 6'd6;
    localparam logic [5:0] OP_IN   = 6'd7;
    localparam logic [5:0] OP_OUT  = 6'd8;
    localparam logic [5:0] OP_HLT  = 6'd9;

    localparam logic [4:0] FUNCT_MAX = 5'd20;

    localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_PASSB = ALUOP_W'(14);
    localparam logic [ALUOP_W-1:0] ALU_JF    = ALUOP_W'(21);

    estado_t estadoQ, estadoD;
    logic [5:0] opReg;
    logic [4:0] functReg;
    logic       ilegalQ;
    logic       decIlegal;
    logic       memConcluida;
    logic [ALUOP_W-1:0] aluOpInstr;
    logic       selBInstr;

    // Decode uses the live IR fields; later states rely on the captured copy.
    assign decIlegal    = (opcode > OP_HLT) || ((opcode == OP_R) && (funct > FUNCT_MAX));
    assign memConcluida = (MEM_HANDSHAKE == 0) || mem_pronto;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estadoQ  <= BUSCA;
            opReg    <= '0;
            functReg <= '0;
            ilegalQ  <= 1'b0;
        end else begin
            estadoQ <= estadoD;
            if (estadoQ == DECODIFICA) begin
                opReg    <= opcode;
                functReg <= funct;
                if (decIlegal) begin
                    ilegalQ <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        estadoD = estadoQ;
        case (estadoQ)
            BUSCA: estadoD = DECODIFICA;
            DECODIFICA: begin
                if (decIlegal) begin
                    estadoD = PARADO;
                end else begin
                    case (opcode)
                        OP_J:    estadoD = BUSCA;
                        OP_HLT:  estadoD = PARADO;
                        OP_IN:   estadoD = ESPERA_IN;
                        default: estadoD = EXECUTA;
                    endcase
                end
            end
            EXECUTA: begin
                case (opReg)
                    OP_JF:        estadoD = BUSCA;
                    OP_LW, OP_SW: estadoD = MEMORIA;
                    OP_OUT:       estadoD = ESPERA_OUT;
                    default:      estadoD = ESCRITA;
                endcase
            end
            MEMORIA: begin
                if (memConcluida) begin
                    estadoD = (opReg == OP_SW) ? BUSCA : ESCRITA;
                end
            end
            ESCRITA: estadoD = BUSCA;
            ESPERA_IN: begin
                if (entrada_valida) begin
                    estadoD = BUSCA;
                end
            end
            ESPERA_OUT: begin
                if (saida_aceita) begin
                    estadoD = BUSCA;
                end
            end
            PARADO:  estadoD = PARADO;
            default: estadoD = BUSCA;
        endcase
    end

    always_comb begin
        aluOpInstr = ALU_PASSB;
        selBInstr  = 1'b0;
        case (opReg)
            OP_R: begin
                aluOpInstr = ALUOP_W'(functReg);
            end
            OP_ADDI, OP_LW, OP_SW: begin
                aluOpInstr = ALU_ADD;
                selBInstr  = 1'b1;
            end
            OP_LI: begin
                aluOpInstr = ALU_PASSB;
                selBInstr  = 1'b1;
            end
            OP_JF: begin
                aluOpInstr = ALU_JF;
                selBInstr  = 1'b1;
            end
            default: begin
                aluOpInstr = ALU_PASSB;
                selBInstr  = 1'b0;
            end
        endcase
    end

    // While reset is held every output sits at its idle value, even though the state reads BUSCA.
    always_comb begin
        aluOp          = ALU_PASSB;
        selB           = 1'b0;
        escreveIR      = 1'b0;
        escrevePC      = 1'b0;
        selPC          = 2'd0;
        escreveReg     = 1'b0;
        selDadoReg     = 2'd0;
        leMem          = 1'b0;
        escreveMem     = 1'b0;
        entrada_pronta = 1'b0;
        saida_valida   = 1'b0;
        parado         = 1'b0;
        if (reset) begin
            case (estadoQ)
                BUSCA: begin
                    escreveIR = 1'b1;
                    escrevePC = 1'b1;
                    selPC     = 2'd0;
                end
                DECODIFICA: begin
                    if (opcode == OP_J) begin
                        escrevePC = 1'b1;
                        selPC     = 2'd1;
                    end
                end
                EXECUTA: begin
                    aluOp = aluOpInstr;
                    selB  = selBInstr;
                    if ((opReg == OP_JF) && flagBranch) begin
                        escrevePC = 1'b1;
                        selPC     = 2'd2;
                    end
                end
                MEMORIA: begin
                    aluOp      = ALU_ADD;
                    selB       = 1'b1;
                    leMem      = (opReg == OP_LW);
                    escreveMem = (opReg == OP_SW);
                end
                ESCRITA: begin
                    aluOp      = aluOpInstr;
                    selB       = selBInstr;
                    escreveReg = 1'b1;
                    selDadoReg = (opReg == OP_LW) ? 2'd1 : 2'd0;
                end
                ESPERA_IN: begin
                    if (entrada_valida) begin
                        escreveReg     = 1'b1;
                        selDadoReg     = 2'd2;
                        entrada_pronta = 1'b1;
                    end
                end
                ESPERA_OUT: begin
                    aluOp        = ALU_PASSB;
                    saida_valida = 1'b1;
                end
                PARADO: begin
                    parado = 1'b1;
                end
                default: begin
                    parado = 1'b0;
                end
            endcase
        end
    end

    assign ilegal = ilegalQ;

`ifdef INSTR_COUNTER_EN
    logic [31:0] contadorQ;

    // PARADO never returns to BUSCA, so the count freezes there naturally.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            contadorQ <= '0;
        end else if ((estadoQ != BUSCA) && (estadoQ != PARADO) && (estadoD == BUSCA)) begin
            contadorQ <= contadorQ + 32'd1;
        end
    end

    assign instr_contador = contadorQ;
`endif

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Directed bench for unidade_controle_multiciclo: per-cycle checks of the control outputs for each instruction class.
// Counter checks are compiled in when INSTR_COUNTER_EN is defined.
module tb_unidade_controle_multiciclo;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] opcode = '0;
    logic [4:0] funct = '0;
    logic       flagBranch = 1'b0;
    logic       mem_pronto = 1'b0;
    logic       entrada_valida = 1'b0;
    logic       saida_aceita = 1'b0;
    logic [4:0] aluOp;
    logic       selB, escreveIR, escrevePC, escreveReg, leMem, escreveMem;
    logic [1:0] selPC, selDadoReg;
    logic       entrada_pronta, saida_valida, parado, ilegal;
`ifdef INSTR_COUNTER_EN
    logic [31:0] instr_contador;
`endif

    int total = 0;
    int bad   = 0;

    unidade_controle_multiciclo #(.MEM_HANDSHAKE(1), .ALUOP_W(5)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .funct(funct),
        .flagBranch(flagBranch), .mem_pronto(mem_pronto),
        .entrada_valida(entrada_valida), .saida_aceita(saida_aceita),
        .aluOp(aluOp), .selB(selB), .escreveIR(escreveIR), .escrevePC(escrevePC),
        .selPC(selPC), .escreveReg(escreveReg), .selDadoReg(selDadoReg),
        .leMem(leMem), .escreveMem(escreveMem), .entrada_pronta(entrada_pronta),
        .saida_valida(saida_valida), .parado(parado), .ilegal(ilegal)
`ifdef INSTR_COUNTER_EN
        , .instr_contador(instr_contador)
`endif
    );

    always #5 clock = ~clock;

    task automatic checa(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        total++;
        if (obs !== esp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
        end
    endtask

    // Advance one clock and sample just after the falling edge.
    task automatic proximo();
        @(negedge clock);
        #1;
    endtask

    task automatic reinicia();
        @(negedge clock);
        reset = 1'b0;
        #1;
        @(negedge clock);
        reset = 1'b1;
        #1;
    endtask

    task automatic instr_alu(input string tag, input logic [5:0] op, input logic [4:0] fn,
                             input logic [4:0] espOp, input logic espSelB);
        checa({tag, "_busca_ir"}, 32'(escreveIR), 32'd1);
        opcode = op;
        funct  = fn;
        proximo();
        checa({tag, "_dec_pc"}, 32'(escrevePC), 32'd0);
        proximo();
        checa({tag, "_exe_aluop"}, 32'(aluOp), 32'(espOp));
        checa({tag, "_exe_selb"}, 32'(selB), 32'(espSelB));
        checa({tag, "_exe_reg"}, 32'(escreveReg), 32'd0);
        proximo();
        checa({tag, "_wb_reg"}, 32'(escreveReg), 32'd1);
        checa({tag, "_wb_sel"}, 32'(selDadoReg), 32'd0);
        proximo();
        checa({tag, "_volta_busca"}, 32'(escreveIR), 32'd1);
    endtask

    initial begin
        int n;
        logic vistoReg;
        logic vistoEn;

        repeat (2) @(negedge clock);
        #1;
        checa("rst_aluop", 32'(aluOp), 32'd14);
        checa("rst_ir", 32'(escreveIR), 32'd0);
        checa("rst_pc", 32'(escrevePC), 32'd0);
        checa("rst_parado", 32'(parado), 32'd0);
        checa("rst_ilegal", 32'(ilegal), 32'd0);

        @(negedge clock);
        reset = 1'b1;
        #1;
        checa("c1_pc", 32'(escrevePC), 32'd1);
        checa("c1_selpc", 32'(selPC), 32'd0);
        checa("c1_reg", 32'(escreveReg), 32'd0);
        instr_alu("add", 6'd0, 5'd0, 5'd0, 1'b0);
        instr_alu("rsub", 6'd0, 5'd3, 5'd3, 1'b0);
        instr_alu("addi", 6'd1, 5'd7, 5'd0, 1'b1);
        instr_alu("li", 6'd4, 5'd0, 5'd14, 1'b1);

        // LW with mem_pronto raised in the third memory cycle
        opcode = 6'd2;
        proximo();
        proximo();
        checa("lw_exe_aluop", 32'(aluOp), 32'd0);
        checa("lw_exe_selb", 32'(selB), 32'd1);
        proximo();
        n = 0;
        for (int i = 0; i < 10 && leMem; i++) begin
            n++;
            if (n == 3) mem_pronto = 1'b1;
            proximo();
        end
        mem_pronto = 1'b0;
        checa("lw_lemem_ciclos", 32'(n), 32'd3);
        checa("lw_wb_reg", 32'(escreveReg), 32'd1);
        checa("lw_wb_sel", 32'(selDadoReg), 32'd1);
        proximo();
        checa("lw_busca_reg", 32'(escreveReg), 32'd0);
        checa("lw_busca_ir", 32'(escreveIR), 32'd1);

        // SW with the same delay, no register write
        opcode = 6'd3;
        proximo();
        proximo();
        vistoReg = escreveReg;
        proximo();
        n = 0;
        for (int i = 0; i < 10 && escreveMem; i++) begin
            n++;
            vistoReg |= escreveReg;
            if (n == 3) mem_pronto = 1'b1;
            proximo();
        end
        mem_pronto = 1'b0;
        checa("sw_escmem_ciclos", 32'(n), 32'd3);
        checa("sw_sem_reg", 32'(vistoReg), 32'd0);
        checa("sw_busca_ir", 32'(escreveIR), 32'd1);

        // JF taken
        opcode = 6'd5;
        proximo();
        flagBranch = 1'b1;
        proximo();
        checa("jf1_aluop", 32'(aluOp), 32'd21);
        checa("jf1_selb", 32'(selB), 32'd1);
        checa("jf1_pc", 32'(escrevePC), 32'd1);
        checa("jf1_selpc", 32'(selPC), 32'd2);
        proximo();
        checa("jf1_busca", 32'(escreveIR), 32'd1);

        // JF not taken
        proximo();
        flagBranch = 1'b0;
        proximo();
        checa("jf0_aluop", 32'(aluOp), 32'd21);
        checa("jf0_pc", 32'(escrevePC), 32'd0);
        proximo();
        checa("jf0_busca", 32'(escreveIR), 32'd1);

        // J resolves in decode
        opcode = 6'd6;
        proximo();
        checa("j_pc", 32'(escrevePC), 32'd1);
        checa("j_selpc", 32'(selPC), 32'd1);
        proximo();
        checa("j_busca", 32'(escreveIR), 32'd1);

        // IN with data arriving after 5 stall cycles
        opcode = 6'd7;
        proximo();
        proximo();
        n = 0;
        vistoReg = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n += int'(entrada_pronta);
            vistoReg |= escreveReg | escreveIR;
            proximo();
        end
        checa("in_espera_quieto", 32'(vistoReg), 32'd0);
        entrada_valida = 1'b1;
        #1;
        n += int'(entrada_pronta);
        checa("in_reg", 32'(escreveReg), 32'd1);
        checa("in_sel", 32'(selDadoReg), 32'd2);
        proximo();
        n += int'(entrada_pronta);
        checa("in_pulsos", 32'(n), 32'd1);
        checa("in_busca", 32'(escreveIR), 32'd1);
        entrada_valida = 1'b0;

        // OUT accepted in the third wait cycle
        opcode = 6'd8;
        proximo();
        proximo();
        checa("out_exe_aluop", 32'(aluOp), 32'd14);
        checa("out_exe_valida", 32'(saida_valida), 32'd0);
        proximo();
        n = 0;
        for (int i = 0; i < 10 && saida_valida; i++) begin
            n++;
            if (n == 3) saida_aceita = 1'b1;
            proximo();
        end
        saida_aceita = 1'b0;
        checa("out_valida_ciclos", 32'(n), 32'd3);
        checa("out_busca", 32'(escreveIR), 32'd1);

        // illegal R-type funct
        opcode = 6'd0;
        funct  = 5'd25;
        proximo();
        proximo();
        checa("ilf_parado", 32'(parado), 32'd1);
        checa("ilf_ilegal", 32'(ilegal), 32'd1);
        vistoEn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vistoEn |= escreveIR | escrevePC | escreveReg | leMem | escreveMem;
            proximo();
        end
        checa("ilf_sem_enables", 32'(vistoEn), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        checa("ilf_rst_ilegal", 32'(ilegal), 32'd0);
        checa("ilf_rst_parado", 32'(parado), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        funct = 5'd0;
        #1;

        // illegal opcode
        opcode = 6'd40;
        proximo();
        proximo();
        checa("ilo_parado", 32'(parado), 32'd1);
        checa("ilo_ilegal", 32'(ilegal), 32'd1);
        reinicia();

        // HLT
        opcode = 6'd9;
        proximo();
        proximo();
        checa("hlt_parado", 32'(parado), 32'd1);
        checa("hlt_ilegal", 32'(ilegal), 32'd0);
        proximo();
        checa("hlt_fica", 32'(parado), 32'd1);
        reinicia();
        checa("hlt_rst", 32'(parado), 32'd0);

        // reset during a stalled SW memory access
        opcode = 6'd3;
        proximo();
        proximo();
        proximo();
        checa("rmem_escmem", 32'(escreveMem), 32'd1);
        reinicia();
        checa("rmem_pos_mem", 32'(escreveMem), 32'd0);
        checa("rmem_pos_reg", 32'(escreveReg), 32'd0);
        checa("rmem_pos_busca", 32'(escreveIR), 32'd1);

`ifdef INSTR_COUNTER_EN
        checa("cnt_rst", instr_contador, 32'd0);
        instr_alu("cnt_a", 6'd0, 5'd0, 5'd0, 1'b0);
        instr_alu("cnt_b", 6'd1, 5'd0, 5'd0, 1'b1);
        opcode = 6'd6;
        proximo();
        proximo();
        opcode = 6'd9;
        proximo();
        proximo();
        checa("cnt_tres", instr_contador, 32'd3);
        repeat (3) proximo();
        checa("cnt_congelado", instr_contador, 32'd3);
        reinicia();
        checa("cnt_zerado", instr_contador, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
